// File: rtl/alarm_zone_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alarm_zone_sequencer
// Description : Arming and reporting controller for a multi-zone security
//               path. Sequences DISARMED -> EXIT_DELAY -> ARMED ->
//               ENTRY_DELAY -> ALARM with programmable timers and keypad
//               disarm-code checking. Tripped zones are latched and reported
//               one at a time over a valid/ready channel with round-robin
//               fairness.
// Ports       : clk, rst_n        clock, asynchronous active-low reset
//               arm_req          single-cycle arm request
//               code_valid       disarm_code is presented this cycle
//               disarm_code[7:0] keypad code
//               zone_trip[N-1:0] raw sensor trip (level)
//               zone_en[N-1:0]   per-zone enable
//               rpt_ready        report sink accepts
//               state[2:0]       current phase
//               armed, siren     registered status outputs
//               arm_fail         one-cycle pulse on a refused arm request
//               rpt_valid        report pending
//               rpt_zone         reported zone index
// Revision    : 1.0  initial release
// ============================================================================
module alarm_zone_sequencer #(
    parameter int unsigned NUM_ZONES   = 4,
    parameter int unsigned EXIT_DLY    = 16,
    parameter int unsigned ENTRY_DLY   = 8,
    parameter int unsigned SIREN_TIME  = 32,
    parameter logic [7:0]  DISARM_CODE = 8'hA5,
    parameter int unsigned MAX_BAD     = 3,
    localparam int unsigned ZONE_W     = $clog2(NUM_ZONES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arm_req,
    input  logic                 code_valid,
    input  logic [7:0]           disarm_code,
    input  logic [NUM_ZONES-1:0] zone_trip,
    input  logic [NUM_ZONES-1:0] zone_en,
    input  logic                 rpt_ready,
    output logic [2:0]           state,
    output logic                 armed,
    output logic                 siren,
    output logic                 arm_fail,
    output logic                 rpt_valid,
    output logic [ZONE_W-1:0]    rpt_zone
);

    typedef enum logic [2:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4
    } state_t;

    localparam logic [7:0]        c_exit_load  = 8'(EXIT_DLY - 1);
    localparam logic [7:0]        c_entry_load = 8'(ENTRY_DLY - 1);
    localparam logic [7:0]        c_siren_load = 8'(SIREN_TIME - 1);
    localparam logic [2:0]        c_max_bad    = 3'(MAX_BAD);
    localparam logic [ZONE_W:0]   c_num_zones  = (ZONE_W + 1)'(NUM_ZONES);
    localparam logic [ZONE_W-1:0] c_last_zone  = ZONE_W'(NUM_ZONES - 1);

    state_t                state_q, state_d;
    logic [7:0]            timer_q, timer_d;
    logic [1:0]            bad_cnt_q, bad_cnt_d;
    logic [NUM_ZONES-1:0]  pending_q, pending_d;
    logic [ZONE_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                  rpt_valid_q, rpt_valid_d;
    logic [ZONE_W-1:0]     rpt_zone_q, rpt_zone_d;
    logic                  siren_q, siren_d;
    logic                  armed_q, armed_d;
    logic                  arm_fail_q, arm_fail_d;

    logic [NUM_ZONES-1:0]  w_trip;
    logic                  w_good;
    logic                  w_bad;
    logic                  w_active;
    logic [2:0]            w_bad_inc;
    logic                  w_bad_force;
    logic [ZONE_W-1:0]     w_sel;
    logic                  w_found;
    logic [ZONE_W:0]       w_cand;

    assign w_trip      = zone_trip & zone_en;
    assign w_good      = code_valid && (disarm_code == DISARM_CODE);
    assign w_bad       = code_valid && !w_good;
    assign w_active    = (state_q != ST_DISARMED);
    assign w_bad_inc   = {1'b0, bad_cnt_q} + 3'd1;
    // The wrong code that would bring the count to MAX_BAD forces ALARM.
    assign w_bad_force = w_active && w_bad && (w_bad_inc == c_max_bad);

    // ------------------------------------------------------------------
    // Phase sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bad_cnt_d  = bad_cnt_q;
        arm_fail_d = 1'b0;

        if (state_q == ST_DISARMED) begin
            bad_cnt_d = 2'd0;
            if (arm_req) begin
                if (w_trip == '0) begin
                    state_d = ST_EXIT_DELAY;
                    timer_d = c_exit_load;
                end else begin
                    arm_fail_d = 1'b1;
                end
            end
        end else if (w_good) begin
            state_d   = ST_DISARMED;
            timer_d   = 8'd0;
            bad_cnt_d = 2'd0;
        end else if (w_bad_force) begin
            // Also taken from ALARM itself, which reloads the siren timer.
            state_d   = ST_ALARM;
            timer_d   = c_siren_load;
            bad_cnt_d = 2'd0;
        end else begin
            if (w_bad) begin
                bad_cnt_d = w_bad_inc[1:0];
            end
            case (state_q)
                ST_EXIT_DELAY: begin
                    if (timer_q == 8'd0) state_d = ST_ARMED;
                    else                 timer_d = timer_q - 8'd1;
                end
                ST_ARMED: begin
                    if (w_trip != '0) begin
                        state_d = ST_ENTRY_DELAY;
                        timer_d = c_entry_load;
                    end
                end
                ST_ENTRY_DELAY: begin
                    if (timer_q == 8'd0) begin
                        state_d = ST_ALARM;
                        timer_d = c_siren_load;
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
                ST_ALARM: begin
                    if (timer_q == 8'd0) state_d = ST_ARMED;
                    else                 timer_d = timer_q - 8'd1;
                end
                default: begin
                    state_d = ST_DISARMED;
                    timer_d = 8'd0;
                end
            endcase
        end

        // Status outputs are registered from the next phase so they change
        // on the same edge as the phase itself.
        armed_d = (state_d == ST_ARMED) || (state_d == ST_ENTRY_DELAY) ||
                  (state_d == ST_ALARM);
        siren_d = (state_d == ST_ALARM);
    end

    // ------------------------------------------------------------------
    // Round-robin search: first pending zone at or above rr_ptr, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            w_cand = {1'b0, rr_ptr_q} + (ZONE_W + 1)'(i);
            if (w_cand >= c_num_zones) begin
                w_cand = w_cand - c_num_zones;
            end
            if (!w_found && pending_q[w_cand[ZONE_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[ZONE_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending latch and report channel
    // ------------------------------------------------------------------
    always_comb begin
        pending_d   = pending_q;
        rr_ptr_d    = rr_ptr_q;
        rpt_valid_d = rpt_valid_q;
        rpt_zone_d  = rpt_zone_q;

        if (w_active && w_good) begin
            // Disarm is the only way a report is withdrawn without handshake.
            pending_d   = '0;
            rr_ptr_d    = '0;
            rpt_valid_d = 1'b0;
        end else begin
            if (rpt_valid_q && rpt_ready) begin
                pending_d[rpt_zone_q] = 1'b0;
                rr_ptr_d    = (rpt_zone_q == c_last_zone) ? '0 : rpt_zone_q + ZONE_W'(1);
                rpt_valid_d = 1'b0;
            end else if (!rpt_valid_q && w_found) begin
                rpt_valid_d = 1'b1;
                rpt_zone_d  = w_sel;
            end
            // Applied after the handshake clear so a re-trip on that cycle wins.
            if ((state_q == ST_ARMED) || (state_q == ST_ENTRY_DELAY) ||
                (state_q == ST_ALARM)) begin
                pending_d = pending_d | w_trip;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_DISARMED;
            timer_q     <= 8'd0;
            bad_cnt_q   <= 2'd0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            rpt_valid_q <= 1'b0;
            rpt_zone_q  <= '0;
            siren_q     <= 1'b0;
            armed_q     <= 1'b0;
            arm_fail_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bad_cnt_q   <= bad_cnt_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_zone_q  <= rpt_zone_d;
            siren_q     <= siren_d;
            armed_q     <= armed_d;
            arm_fail_q  <= arm_fail_d;
        end
    end

    assign state     = state_q;
    assign armed     = armed_q;
    assign siren     = siren_q;
    assign arm_fail  = arm_fail_q;
    assign rpt_valid = rpt_valid_q;
    assign rpt_zone  = rpt_zone_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_zone_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_zone_sequencer
// Description : Self-checking bench for alarm_zone_sequencer. Directed
//               scenarios followed by randomized stimulus, all compared every
//               cycle against a behavioural phase/report model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alarm_zone_sequencer;

    localparam int         NZ         = 4;
    localparam int         EXIT_DLY   = 16;
    localparam int         ENTRY_DLY  = 8;
    localparam int         SIREN_TIME = 32;
    localparam int         MAX_BAD    = 3;
    localparam logic [7:0] CODE       = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm_req = 1'b0;
    logic          code_valid = 1'b0;
    logic [7:0]    disarm_code = 8'h00;
    logic [NZ-1:0] zone_trip = '0;
    logic [NZ-1:0] zone_en = '1;
    logic          rpt_ready = 1'b0;
    logic [2:0]    state;
    logic          armed, siren, arm_fail, rpt_valid;
    logic [1:0]    rpt_zone;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (phase number, timer, counters, flag array).
    int m_state, m_timer, m_bad, m_rr, m_zone;
    bit m_valid, m_fail;
    bit m_pend [NZ];

    always #5 clk = ~clk;

    alarm_zone_sequencer #(
        .NUM_ZONES  (NZ),
        .EXIT_DLY   (EXIT_DLY),
        .ENTRY_DLY  (ENTRY_DLY),
        .SIREN_TIME (SIREN_TIME),
        .DISARM_CODE(CODE),
        .MAX_BAD    (MAX_BAD)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm_req    (arm_req),
        .code_valid (code_valid),
        .disarm_code(disarm_code),
        .zone_trip  (zone_trip),
        .zone_en    (zone_en),
        .rpt_ready  (rpt_ready),
        .state      (state),
        .armed      (armed),
        .siren      (siren),
        .arm_fail   (arm_fail),
        .rpt_valid  (rpt_valid),
        .rpt_zone   (rpt_zone)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_timer = 0; m_bad = 0; m_rr = 0; m_zone = 0;
        m_valid = 0; m_fail = 0;
        for (int k = 0; k < NZ; k++) m_pend[k] = 0;
    endtask

    task automatic model_step();
        bit t [NZ];
        bit any_t, any_p, g, b, nf, nv;
        int ns, nt, nb, nrr, nz;
        bit np [NZ];
        any_t = 0; any_p = 0;
        for (int k = 0; k < NZ; k++) begin
            t[k] = zone_trip[k] & zone_en[k];
            any_t |= t[k];
            any_p |= m_pend[k];
            np[k] = m_pend[k];
        end
        g = code_valid && (disarm_code == CODE);
        b = code_valid && !g;

        ns = m_state; nt = m_timer; nb = m_bad; nf = 0;
        if (m_state == 0) begin
            nb = 0;
            if (arm_req) begin
                if (!any_t) begin ns = 1; nt = EXIT_DLY - 1; end
                else nf = 1;
            end
        end else if (g) begin
            ns = 0; nb = 0;
        end else if (b && (m_bad + 1 == MAX_BAD)) begin
            ns = 4; nt = SIREN_TIME - 1; nb = 0;
        end else begin
            if (b) nb = m_bad + 1;
            case (m_state)
                1: if (m_timer == 0) ns = 2; else nt = m_timer - 1;
                2: if (any_t) begin ns = 3; nt = ENTRY_DLY - 1; end
                3: if (m_timer == 0) begin ns = 4; nt = SIREN_TIME - 1; end
                   else nt = m_timer - 1;
                default: if (m_timer == 0) ns = 2; else nt = m_timer - 1;
            endcase
        end

        nrr = m_rr; nz = m_zone; nv = m_valid;
        if (m_state != 0 && g) begin
            for (int k = 0; k < NZ; k++) np[k] = 0;
            nrr = 0; nv = 0;
        end else begin
            if (m_valid && rpt_ready) begin
                np[m_zone] = 0;
                nrr = (m_zone + 1) % NZ;
                nv = 0;
            end else if (!m_valid && any_p) begin
                for (int k = NZ - 1; k >= 0; k--)
                    if (m_pend[(m_rr + k) % NZ]) nz = (m_rr + k) % NZ;
                nv = 1;
            end
            if (m_state >= 2)
                for (int k = 0; k < NZ; k++) np[k] |= t[k];
        end

        m_state = ns; m_timer = nt; m_bad = nb; m_fail = nf;
        m_rr = nrr; m_zone = nz; m_valid = nv;
        for (int k = 0; k < NZ; k++) m_pend[k] = np[k];
    endtask

    // Called just after a rising edge: model the coming edge, then compare.
    task automatic cycle();
        if (!rst_n) model_reset();
        else        model_step();
        @(posedge clk);
        #1;
        check_eq("state",     int'(state),     m_state);
        check_eq("armed",     int'(armed),     int'(m_state >= 2));
        check_eq("siren",     int'(siren),     int'(m_state == 4));
        check_eq("arm_fail",  int'(arm_fail),  int'(m_fail));
        check_eq("rpt_valid", int'(rpt_valid), int'(m_valid));
        if (m_valid) check_eq("rpt_zone", int'(rpt_zone), m_zone);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic idle();
        arm_req = 0; code_valid = 0; disarm_code = 8'h00;
        zone_trip = '0; zone_en = '1; rpt_ready = 0;
    endtask

    task automatic disarm();
        code_valid = 1; disarm_code = CODE;
        cycle();
        code_valid = 0; disarm_code = 8'h00;
    endtask

    task automatic arm_to_armed();
        arm_req = 1;
        cycle();
        arm_req = 0;
        run_cycles(EXIT_DLY);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, guard;
        bit retrip;
        int hs [$];
        int exp_seq [4] = '{0, 1, 3, 0};

        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state",     int'(state),     0);
        check_eq("rst_armed",     int'(armed),     0);
        check_eq("rst_siren",     int'(siren),     0);
        check_eq("rst_arm_fail",  int'(arm_fail),  0);
        check_eq("rst_rpt_valid", int'(rpt_valid), 0);
        check_eq("rst_rpt_zone",  int'(rpt_zone),  0);
        model_reset();
        rst_n = 1;
        run_cycles(2);

        // Exit delay length, trips ignored throughout.
        arm_req = 1;
        cycle();
        arm_req = 0;
        n1 = (state == 3'd1) ? 1 : 0;
        guard = 0;
        while (state == 3'd1 && guard < 300) begin
            zone_trip = NZ'($urandom);
            cycle();
            guard++;
            if (state == 3'd1) n1++;
        end
        zone_trip = '0;
        check_eq("exit_len", n1, EXIT_DLY);
        run_cycles(3);
        check_eq("exit_state", int'(state), 2);
        check_eq("exit_no_report", int'(rpt_valid), 0);
        disarm();

        // Refused arm, then the same trip masked by zone_en.
        zone_trip = 4'b0010;
        arm_req = 1;
        cycle();
        arm_req = 0;
        check_eq("arm_fail_pulse", int'(arm_fail), 1);
        check_eq("arm_fail_state", int'(state), 0);
        cycle();
        check_eq("arm_fail_clear", int'(arm_fail), 0);
        zone_en = 4'b1101;
        arm_req = 1;
        cycle();
        arm_req = 0;
        check_eq("arm_masked", int'(state), 1);
        zone_trip = '0; zone_en = '1;
        run_cycles(EXIT_DLY);
        check_eq("armed_after_exit", int'(state), 2);

        // Zone 2: entry delay, alarm, report held under backpressure.
        rpt_ready = 0;
        zone_trip = 4'b0100;
        cycle();
        zone_trip = '0;
        check_eq("entry_start", int'(state), 3);
        run_cycles(6);
        check_eq("rpt_hold_valid", int'(rpt_valid), 1);
        check_eq("rpt_hold_zone", int'(rpt_zone), 2);
        rpt_ready = 1;
        cycle();
        rpt_ready = 0;
        check_eq("rpt_hs_drop", int'(rpt_valid), 0);
        check_eq("entry_last", int'(state), 3);
        cycle();
        check_eq("alarm_enter", int'(state), 4);
        check_eq("alarm_siren", int'(siren), 1);
        run_cycles(SIREN_TIME - 1);
        check_eq("alarm_hold", int'(state), 4);
        cycle();
        check_eq("alarm_exit", int'(state), 2);
        check_eq("alarm_siren_off", int'(siren), 0);
        disarm();

        // Round-robin order with a re-trip on zone 0's handshake.
        arm_to_armed();
        rpt_ready = 1;
        zone_trip = 4'b1011;
        cycle();
        zone_trip = '0;
        retrip = 0;
        for (int c = 0; c < 20; c++) begin
            if (rpt_valid && rpt_zone == 2'd0 && !retrip) begin
                zone_trip = 4'b0001;
                retrip = 1;
            end else begin
                zone_trip = '0;
            end
            if (rpt_valid && rpt_ready) hs.push_back(int'(rpt_zone));
            cycle();
        end
        zone_trip = '0;
        rpt_ready = 0;
        check_eq("rr_count", hs.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < hs.size()) check_eq("rr_order", hs[k], exp_seq[k]);
        disarm();

        // Good code on the last entry-delay cycle wins over expiry.
        arm_to_armed();
        zone_trip = 4'b0010;
        cycle();
        zone_trip = '0;
        run_cycles(7);
        check_eq("entry_t0_state", int'(state), 3);
        check_eq("entry_t0_report", int'(rpt_valid), 1);
        disarm();
        check_eq("good_beats_expiry", int'(state), 0);
        check_eq("good_drops_report", int'(rpt_valid), 0);
        run_cycles(3);
        check_eq("pending_cleared", int'(rpt_valid), 0);

        // Three wrong codes in ARMED force ALARM.
        arm_to_armed();
        code_valid = 1; disarm_code = 8'h12;
        run_cycles(2);
        check_eq("bad2_armed", int'(state), 2);
        cycle();
        code_valid = 0;
        check_eq("bad3_alarm", int'(state), 4);
        disarm();

        // Asynchronous reset in ALARM with a report outstanding.
        arm_to_armed();
        rpt_ready = 0;
        zone_trip = 4'b0001;
        cycle();
        zone_trip = '0;
        run_cycles(8);
        check_eq("pre_rst_state", int'(state), 4);
        check_eq("pre_rst_valid", int'(rpt_valid), 1);
        #2;
        rst_n = 0;
        #1;
        check_eq("async_rst_state", int'(state), 0);
        check_eq("async_rst_siren", int'(siren), 0);
        check_eq("async_rst_armed", int'(armed), 0);
        check_eq("async_rst_valid", int'(rpt_valid), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        run_cycles(2);

        // Randomized traffic, occasional mid-operation reset.
        for (int i = 0; i < 3000; i++) begin
            arm_req     = ($urandom_range(0, 5) == 0);
            code_valid  = ($urandom_range(0, 9) == 0);
            disarm_code = ($urandom_range(0, 1) == 0) ? CODE : 8'($urandom);
            zone_trip   = ($urandom_range(0, 4) == 0) ? NZ'($urandom) : '0;
            zone_en     = ($urandom_range(0, 3) == 0) ? NZ'($urandom) : '1;
            rpt_ready   = $urandom_range(0, 1) == 1;
            rst_n       = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst_n = 1;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
